// File: rtl/blink_rate_ctrl.sv
// Button-stepped blink-rate selector: debounced press cycles four rates, prescaler emits a one-cycle TICK.
// Optional macro BLINK_HOLD_EN adds a HOLD input that freezes the prescaler.
module blink_rate_ctrl #(
   parameter int DIV_BASE        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = $clog2(DIV_BASE)
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       BTN,
`ifdef BLINK_HOLD_EN
   input  logic       HOLD,
`endif
   output logic       TICK,
   output logic [1:0] RATE_SEL,
   output logic [3:0] RATE_LED
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2, R3 = 2'd3} rate_t;

   logic            s1, s2;
   logic            stable, stable_d;
   logic [DB_W-1:0] db_cnt;
   logic            press;
   rate_t           state_q, state_d;
   logic [3:0]      led_q, led_d;
   logic [CNT_W-1:0] cnt, cnt_last;
   logic            tick_q;
   logic            hold_i;

`ifdef BLINK_HOLD_EN
   assign hold_i = HOLD;
`else
   assign hold_i = 1'b0;
`endif

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= BTN;
         s2 <= s1;
      end
   end

   // Any mismatch that ends before the counter saturates is simply forgotten.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         stable   <= 1'b0;
         stable_d <= 1'b0;
         db_cnt   <= '0;
      end else begin
         stable_d <= stable;
         if (s2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable <= s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   assign press = stable & ~stable_d;

   always_comb begin
      state_d = state_q;
      led_d   = 4'b0001;
      if (press) begin
         case (state_q)
            R0:      state_d = R1;
            R1:      state_d = R2;
            R2:      state_d = R3;
            default: state_d = R0;
         endcase
      end
      case (state_d)
         R0:      led_d = 4'b0001;
         R1:      led_d = 4'b0010;
         R2:      led_d = 4'b0100;
         default: led_d = 4'b1000;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= R0;
         led_q   <= 4'b0001;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
      end
   end

   always_comb begin
      cnt_last = CNT_W'(DIV_BASE - 1);
      case (state_q)
         R0:      cnt_last = CNT_W'(DIV_BASE - 1);
         R1:      cnt_last = CNT_W'((DIV_BASE >> 1) - 1);
         R2:      cnt_last = CNT_W'((DIV_BASE >> 2) - 1);
         default: cnt_last = CNT_W'((DIV_BASE >> 3) - 1);
      endcase
   end

   // TICK is a strobe, not a handshake: high for exactly one cycle per period, no back-pressure.
   // A rate change restarts the period and swallows a coincident terminal count.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         cnt    <= '0;
         tick_q <= 1'b0;
      end else if (press) begin
         cnt    <= '0;
         tick_q <= 1'b0;
      end else if (hold_i) begin
         tick_q <= 1'b0;
      end else if (cnt == cnt_last) begin
         cnt    <= '0;
         tick_q <= 1'b1;
      end else begin
         cnt    <= cnt + CNT_W'(1);
         tick_q <= 1'b0;
      end
   end

   assign TICK     = tick_q;
   assign RATE_SEL = state_q;
   assign RATE_LED = led_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed bench for blink_rate_ctrl (DEBOUNCE_CYCLES=4, DIV_BASE=16); define BLINK_HOLD_EN to cover HOLD.
module tb_blink_rate_ctrl;

   localparam int DB  = 4;
   localparam int DIV = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
`ifdef BLINK_HOLD_EN
   logic       hold;
`endif
   logic       tick;
   logic [1:0] rate_sel;
   logic [3:0] rate_led;

   blink_rate_ctrl #(.DIV_BASE(DIV), .DEBOUNCE_CYCLES(DB)) dut (
      .CLOCK    (clk),
      .RESET    (rst),
      .BTN      (btn),
`ifdef BLINK_HOLD_EN
      .HOLD     (hold),
`endif
      .TICK     (tick),
      .RATE_SEL (rate_sel),
      .RATE_LED (rate_led)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // expected tick cycles, and expected {cycle, rate, led} at every RATE_SEL change
   logic [31:0] exp_q[$];
   logic [37:0] rate_q[$];

   int next_tick;
   int period;
   int cur_rate;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: outputs sampled on the falling edge
   logic [1:0]  prev_sel = 2'd0;
   logic [31:0] e_tick;
   logic [37:0] e_rate;
   always @(negedge clk) begin
      if (tick === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tick_unexpected actual_cycle=%0d expected=none", cyc);
         end else begin
            e_tick = exp_q.pop_front();
            if (e_tick != 32'(cyc)) begin
               errors++;
               $display("FAIL tick_cycle actual=%0d expected=%0d", cyc, e_tick);
            end
         end
      end
      if (rate_sel !== prev_sel) begin
         checks++;
         if (rate_q.size() == 0) begin
            errors++;
            $display("FAIL rate_unexpected actual_rate=%0d cycle=%0d expected=none", rate_sel, cyc);
         end else begin
            e_rate = rate_q.pop_front();
            if ({32'(cyc), rate_sel, rate_led} !== e_rate) begin
               errors++;
               $display("FAIL rate_change actual cyc=%0d sel=%0d led=%b expected cyc=%0d sel=%0d led=%b",
                        cyc, rate_sel, rate_led, e_rate[37:6], e_rate[5:4], e_rate[3:0]);
            end
         end
      end
      prev_sel = rate_sel;
   end

   // driver tasks
   task automatic push_ticks(input int upto);
      while (next_tick <= upto) begin
         exp_q.push_back(32'(next_tick));
         next_tick += period;
      end
   endtask

   task automatic run(input int n);
      push_ticks(cyc + n);
      repeat (n) @(negedge clk);
   endtask

   // BTN rises at this negedge; the rate changes at the 7th rising edge after it.
   task automatic press(input int high_cycles, input bit align);
      int t;
      int c;
      logic [3:0] led;
      if (align) begin
         t = next_tick;
         while (t < cyc + 7) t += period;
         run(t - 7 - cyc);
      end
      btn = 1'b1;
      c = cyc + 7;
      push_ticks(c - 1);
      cur_rate = (cur_rate + 1) % 4;
      period = DIV >> cur_rate;
      case (cur_rate)
         0:       led = 4'b0001;
         1:       led = 4'b0010;
         2:       led = 4'b0100;
         default: led = 4'b1000;
      endcase
      rate_q.push_back({32'(c), 2'(cur_rate), led});
      next_tick = c + period;
      run(high_cycles);
      btn = 1'b0;
      run(12);
   endtask

   task automatic reset_pulse();
      int s;
      s = cyc;
      rst = 1'b1;
      push_ticks(s);
      if (cur_rate != 0) rate_q.push_back({32'(s + 1), 2'd0, 4'b0001});
      @(negedge clk);
      check("reset_tick_low", {31'd0, tick}, 32'd0);
      rst = 1'b0;
      cur_rate = 0;
      period = DIV;
      next_tick = s + 1 + DIV;
   endtask

   // stimulus
   initial begin
      rst = 1'b1;
      btn = 1'b0;
`ifdef BLINK_HOLD_EN
      hold = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("reset_rate_sel", {30'd0, rate_sel}, 32'd0);
      check("reset_rate_led", {28'd0, rate_led}, 32'd1);
      check("reset_tick", {31'd0, tick}, 32'd0);
      rst = 1'b0;
      cur_rate = 0;
      period = DIV;
      next_tick = cyc + DIV;
      run(40);

      // bounce: 2 high, 2 low, 3 high -> no rate change
      btn = 1'b1; run(2);
      btn = 1'b0; run(2);
      btn = 1'b1; run(3);
      btn = 1'b0; run(30);
      check("bounce_rate_sel", {30'd0, rate_sel}, 32'd0);

      // wrap through all four rates; third press lands on a terminal count
      press(20, 1'b0); run(30);
      press(20, 1'b0); run(20);
      press(20, 1'b1); run(10);
      press(20, 1'b0); run(40);
      check("wrap_rate_sel", {30'd0, rate_sel}, 32'd0);

      // press at rate 2 landing mid-count, then reset pulse at rate 2
      press(20, 1'b0); run(17);
      press(20, 1'b0); run(5);
      press(20, 1'b0); run(9);
      press(20, 1'b0); run(20);
      press(20, 1'b0); run(9);
      press(20, 1'b0); run(6);
      check("pre_reset_rate_sel", {30'd0, rate_sel}, 32'd2);
      reset_pulse();
      check("post_reset_rate_led", {28'd0, rate_led}, 32'd1);
      run(40);

`ifdef BLINK_HOLD_EN
      begin
         int t;
         t = next_tick;
         while (t < cyc + 6) t += period;
         run(t - 6 - cyc);
         hold = 1'b1;
         next_tick += 30;
         run(30);
         hold = 1'b0;
         run(40);
      end
`endif

      run(20);
      check("tick_queue_drained", 32'(exp_q.size()), 32'd0);
      check("rate_queue_drained", 32'(rate_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
